// File: rtl/coin_change_dispenser.sv
// Change payout engine: pays a refund amount as greedy 5/2/1 coins over a valid/ack hopper handshake.
// Optional hopper-timeout fault state is built when COIN_TIMEOUT_EN is defined.
module coin_change_dispenser #(
    parameter int AMT_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             coin_valid,
    output logic [2:0]       coin_val,
    input  logic             coin_ack,
    output logic             done,
    output logic [AMT_W-1:0] coins_issued,
    output logic             fault
);

`ifdef COIN_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_FAULT} state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] coins_q, coins_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [2:0]       val_q, val_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            coins_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            val_q   <= 3'd0;
            done_q  <= 1'b0;
`ifdef COIN_TIMEOUT_EN
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coins_q <= coins_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            val_q   <= val_d;
            done_q  <= done_d;
`ifdef COIN_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        coins_d = coins_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        val_d   = val_q;
        done_d  = 1'b0;
`ifdef COIN_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rem_d   = amount;
                    coins_d = '0;
                    busy_d  = 1'b1;
                    state_d = (amount == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                // Greedy pick; rem is never zero here, so the smallest coin always fits.
                if (int'(rem_q) >= 5)      val_d = 3'd5;
                else if (int'(rem_q) >= 2) val_d = 3'd2;
                else                       val_d = 3'd1;
                valid_d = 1'b1;
                state_d = S_ISSUE;
`ifdef COIN_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_ISSUE: begin
                if (coin_ack) begin
                    rem_d   = rem_q - AMT_W'(val_q);
                    coins_d = coins_q + 1'b1;
                    valid_d = 1'b0;
                    val_d   = 3'd0;
                    state_d = (rem_q == AMT_W'(val_q)) ? S_DONE : S_SELECT;
                end
`ifdef COIN_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    valid_d = 1'b0;
                    val_d   = 3'd0;
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`ifdef COIN_TIMEOUT_EN
            S_FAULT: begin
                // Parked until reset; busy stays high so the vend FSM cannot start another refund.
                state_d = S_FAULT;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = busy_q;
    assign coin_valid   = valid_q;
    assign coin_val     = val_q;
    assign done         = done_q;
    assign coins_issued = coins_q;
`ifdef COIN_TIMEOUT_EN
    assign fault = fault_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign fault = 1'b0;
`endif

endmodule
